// File: rtl/pure_literal_scanner_if.sv
// Handshake and formula bus between the clause store, the pure-literal scanner
// and the assignment unit.
interface pure_literal_scanner_if #(
    parameter int VAR_W       = 3,
    parameter int MAX_LITS    = 5,
    parameter int MAX_CLAUSES = 10
);
    localparam int LIT_W = VAR_W + 1;
    localparam int LEN_W = $clog2(MAX_LITS + 1);
    localparam int CL_W  = $clog2(MAX_CLAUSES + 1);

    logic                                  start;
    logic [MAX_CLAUSES*MAX_LITS*LIT_W-1:0] clause_lits;
    logic [MAX_CLAUSES*LEN_W-1:0]          clause_len;
    logic [MAX_CLAUSES-1:0]                clause_act;
    logic [CL_W-1:0]                       num_clauses;
    logic                                  busy;
    logic                                  done;
    logic                                  found;
    logic                                  lit_valid;
    logic                                  lit_ready;
    logic [VAR_W-1:0]                      lit_var;
    logic                                  lit_pol;
    logic [VAR_W-1:0]                      pure_count;

    modport master (
        output start, clause_lits, clause_len, clause_act, num_clauses, lit_ready,
        input  busy, done, found, lit_valid, lit_var, lit_pol, pure_count
    );

    modport slave (
        input  start, clause_lits, clause_len, clause_act, num_clauses, lit_ready,
        output busy, done, found, lit_valid, lit_var, lit_pol, pure_count
    );
endinterface

// File: rtl/pure_literal_scanner.sv
// Pure-literal finder: tallies variable polarities one clause per cycle, then
// streams pure literals in ascending variable order over a valid/ready port.
module pure_literal_scanner #(
    parameter int VAR_W       = 3,
    parameter int MAX_LITS    = 5,
    parameter int MAX_CLAUSES = 10,
    parameter int FIND_ALL    = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    pure_literal_scanner_if.slave bus
);
    localparam int LIT_W = VAR_W + 1;
    localparam int LEN_W = $clog2(MAX_LITS + 1);
    localparam int CL_W  = $clog2(MAX_CLAUSES + 1);
    localparam int NV    = 2**VAR_W - 1;

    localparam logic [CL_W-1:0]  MAXC       = CL_W'(MAX_CLAUSES);
    localparam logic [LEN_W-1:0] MAXL       = LEN_W'(MAX_LITS);
    localparam logic [VAR_W-1:0] LASTV      = VAR_W'(NV);
    localparam bit               STOP_FIRST = (FIND_ALL == 0);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;
    state_t state, state_nxt;

    logic [MAX_CLAUSES*MAX_LITS*LIT_W-1:0] lits_q;
    logic [MAX_CLAUSES*LEN_W-1:0]          len_q;
    logic [MAX_CLAUSES-1:0]                act_q;
    logic [CL_W-1:0]                       ncl_q;
    logic [CL_W-1:0]                       cidx_q;
    logic [VAR_W-1:0]                      v_q;
    logic [VAR_W-1:0]                      cnt_q;
    logic [NV:0]                           pos_q;
    logic [NV:0]                           neg_q;
    logic                                  found_q;

    logic [CL_W-1:0]  ncl_in;
    logic [LEN_W-1:0] cur_len;
    logic             cur_act;
    logic [LIT_W-1:0] cur_lit [MAX_LITS];
    logic [NV:0]      pos_set;
    logic [NV:0]      neg_set;
    logic             pure_v;
    logic             lit_valid;
    logic             hs;
    logic             advance;
    logic             last_v;

    assign ncl_in = (bus.num_clauses > MAXC) ? MAXC : bus.num_clauses;

    always_comb begin : clause_select
        cur_len = '0;
        cur_act = 1'b0;
        for (int unsigned s = 0; s < MAX_LITS; s++) cur_lit[s] = '0;
        for (int unsigned c = 0; c < MAX_CLAUSES; c++) begin
            if (CL_W'(c) == cidx_q) begin
                cur_len = len_q[c*LEN_W +: LEN_W];
                cur_act = act_q[c];
                for (int unsigned s = 0; s < MAX_LITS; s++)
                    cur_lit[s] = lits_q[(c*MAX_LITS + s)*LIT_W +: LIT_W];
            end
        end
        if (cur_len > MAXL) cur_len = MAXL;
    end

    // Var 0 marks an empty slot and never reaches the bitmaps.
    always_comb begin : tally
        pos_set = '0;
        neg_set = '0;
        for (int unsigned s = 0; s < MAX_LITS; s++) begin
            if (cur_act && (LEN_W'(s) < cur_len) && (cur_lit[s][LIT_W-1:1] != '0)) begin
                if (cur_lit[s][0]) pos_set[cur_lit[s][LIT_W-1:1]] = 1'b1;
                else               neg_set[cur_lit[s][LIT_W-1:1]] = 1'b1;
            end
        end
    end

    assign pure_v    = pos_q[v_q] ^ neg_q[v_q];
    assign lit_valid = (state == EMIT) && pure_v;
    assign hs        = lit_valid && bus.lit_ready;
    assign advance   = (state == EMIT) && (!pure_v || bus.lit_ready);
    assign last_v    = (v_q == LASTV);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin : next_state
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = (ncl_in == '0) ? EMIT : SCAN;
            SCAN: if (cidx_q == ncl_q - CL_W'(1)) state_nxt = EMIT;
            EMIT: begin
                if (hs && STOP_FIRST)       state_nxt = DONE;
                else if (advance && last_v) state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lits_q  <= '0;
            len_q   <= '0;
            act_q   <= '0;
            ncl_q   <= '0;
            cidx_q  <= '0;
            v_q     <= '0;
            cnt_q   <= '0;
            pos_q   <= '0;
            neg_q   <= '0;
            found_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        lits_q  <= bus.clause_lits;
                        len_q   <= bus.clause_len;
                        act_q   <= bus.clause_act;
                        ncl_q   <= ncl_in;
                        cidx_q  <= '0;
                        v_q     <= VAR_W'(1);
                        cnt_q   <= '0;
                        pos_q   <= '0;
                        neg_q   <= '0;
                        found_q <= 1'b0;
                    end
                end
                SCAN: begin
                    pos_q  <= pos_q | pos_set;
                    neg_q  <= neg_q | neg_set;
                    cidx_q <= cidx_q + CL_W'(1);
                end
                EMIT: begin
                    if (hs) begin
                        cnt_q   <= cnt_q + VAR_W'(1);
                        found_q <= 1'b1;
                    end
                    if (advance) v_q <= v_q + VAR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = (state == SCAN) || (state == EMIT);
    assign bus.done       = (state == DONE);
    assign bus.found      = found_q;
    assign bus.lit_valid  = lit_valid;
    assign bus.lit_var    = lit_valid ? v_q : '0;
    assign bus.lit_pol    = lit_valid & pos_q[v_q];
    assign bus.pure_count = cnt_q;
endmodule

// File: tb/tb_pure_literal_scanner.sv
// Bench for pure_literal_scanner: directed scenarios plus randomized formulas
// checked against a clause-list reference model.
module tb_pure_literal_scanner;
    localparam int VAR_W       = 3;
    localparam int MAX_LITS    = 5;
    localparam int MAX_CLAUSES = 10;
    localparam int LIT_W       = VAR_W + 1;
    localparam int LEN_W       = 3;
    localparam int NV          = 7;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pure_literal_scanner_if #(.VAR_W(VAR_W), .MAX_LITS(MAX_LITS), .MAX_CLAUSES(MAX_CLAUSES)) bus_a ();
    pure_literal_scanner_if #(.VAR_W(VAR_W), .MAX_LITS(MAX_LITS), .MAX_CLAUSES(MAX_CLAUSES)) bus_b ();

    pure_literal_scanner #(.VAR_W(VAR_W), .MAX_LITS(MAX_LITS), .MAX_CLAUSES(MAX_CLAUSES), .FIND_ALL(1))
        dut_a (.clock(clk), .reset(rst_n), .bus(bus_a.slave));
    pure_literal_scanner #(.VAR_W(VAR_W), .MAX_LITS(MAX_LITS), .MAX_CLAUSES(MAX_CLAUSES), .FIND_ALL(0))
        dut_b (.clock(clk), .reset(rst_n), .bus(bus_b.slave));

    int tests = 0;
    int fails = 0;

    int fv [MAX_CLAUSES][MAX_LITS];
    int fp [MAX_CLAUSES][MAX_LITS];
    int flen [MAX_CLAUSES];
    int fact [MAX_CLAUSES];
    int fnc;

    int exp_v[$], exp_p[$];
    int exp_done;
    int got_v[$], got_p[$];
    int done_cyc;
    logic [31:0] got_found, got_cnt;
    logic [31:0] s_busy, s_done, s_found, s_valid, s_var, s_pol, s_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic grab(input bit sel);
        if (sel) begin
            s_busy = 32'(bus_b.busy); s_done = 32'(bus_b.done); s_found = 32'(bus_b.found);
            s_valid = 32'(bus_b.lit_valid); s_var = 32'(bus_b.lit_var);
            s_pol = 32'(bus_b.lit_pol); s_cnt = 32'(bus_b.pure_count);
        end else begin
            s_busy = 32'(bus_a.busy); s_done = 32'(bus_a.done); s_found = 32'(bus_a.found);
            s_valid = 32'(bus_a.lit_valid); s_var = 32'(bus_a.lit_var);
            s_pol = 32'(bus_a.lit_pol); s_cnt = 32'(bus_a.pure_count);
        end
    endtask

    task automatic check_idle_zero(input string tag, input bit sel);
        grab(sel);
        check({tag, "_busy"}, s_busy, 0);
        check({tag, "_done"}, s_done, 0);
        check({tag, "_found"}, s_found, 0);
        check({tag, "_valid"}, s_valid, 0);
        check({tag, "_var"}, s_var, 0);
        check({tag, "_pol"}, s_pol, 0);
        check({tag, "_cnt"}, s_cnt, 0);
    endtask

    task automatic drive();
        logic [LIT_W-1:0] l;
        logic [LEN_W-1:0] n;
        for (int c = 0; c < MAX_CLAUSES; c++) begin
            for (int s = 0; s < MAX_LITS; s++) begin
                l = {fv[c][s][VAR_W-1:0], fp[c][s][0]};
                bus_a.clause_lits[(c*MAX_LITS + s)*LIT_W +: LIT_W] = l;
                bus_b.clause_lits[(c*MAX_LITS + s)*LIT_W +: LIT_W] = l;
            end
            n = flen[c][LEN_W-1:0];
            bus_a.clause_len[c*LEN_W +: LEN_W] = n;
            bus_b.clause_len[c*LEN_W +: LEN_W] = n;
            bus_a.clause_act[c] = fact[c][0];
            bus_b.clause_act[c] = fact[c][0];
        end
        bus_a.num_clauses = fnc[3:0];
        bus_b.num_clauses = fnc[3:0];
    endtask

    task automatic set_clause(input int c, input int len, input int a, input int b,
                              input int d, input int e, input int f);
        int l[MAX_LITS];
        l = '{a, b, d, e, f};
        for (int s = 0; s < MAX_LITS; s++) begin
            fv[c][s] = (l[s] < 0) ? -l[s] : l[s];
            fp[c][s] = (l[s] > 0) ? 1 : 0;
        end
        flen[c] = len;
        fact[c] = 1;
    endtask

    task automatic set_t1();
        fnc = 10;
        set_clause(0, 5,  1,  2,  3, 4, 5);
        set_clause(1, 2, -2, -5,  0, 0, 0);
        set_clause(2, 3, -1, -2, -5, 0, 0);
        set_clause(3, 2,  1,  2,  0, 0, 0);
        set_clause(4, 1,  1,  0,  0, 0, 0);
        set_clause(5, 1,  2,  0,  0, 0, 0);
        set_clause(6, 1,  3,  0,  0, 0, 0);
        set_clause(7, 1,  4,  0,  0, 0, 0);
        set_clause(8, 3, -2, -3,  4, 0, 0);
        set_clause(9, 2, -3,  2,  0, 0, 0);
    endtask

    // Reference: which variables appear with which signs, then the timing rule.
    task automatic model(input bit find_all, input int stall_var, input int stall_n);
        int pos[NV+1], neg[NV+1];
        int n, len, stalls;
        exp_v.delete(); exp_p.delete();
        for (int v = 0; v <= NV; v++) begin pos[v] = 0; neg[v] = 0; end
        n = (fnc > MAX_CLAUSES) ? MAX_CLAUSES : fnc;
        for (int c = 0; c < n; c++) begin
            len = (flen[c] > MAX_LITS) ? MAX_LITS : flen[c];
            if (fact[c] != 0)
                for (int s = 0; s < len; s++)
                    if (fv[c][s] != 0) begin
                        if (fp[c][s] != 0) pos[fv[c][s]] = 1;
                        else               neg[fv[c][s]] = 1;
                    end
        end
        for (int v = 1; v <= NV; v++) begin
            if (pos[v] != neg[v] && (find_all || exp_v.size() == 0)) begin
                exp_v.push_back(v);
                exp_p.push_back(pos[v]);
            end
        end
        stalls = 0;
        foreach (exp_v[i]) if (exp_v[i] == stall_var) stalls = stall_n;
        if (find_all || exp_v.size() == 0) exp_done = 1 + n + NV + stalls;
        else                               exp_done = n + exp_v[0] + 1 + stalls;
    endtask

    task automatic set_ready(input logic r);
        bus_a.lit_ready = r;
        bus_b.lit_ready = r;
    endtask

    task automatic set_start(input bit sel, input logic v);
        if (sel) bus_b.start = v; else bus_a.start = v;
    endtask

    task automatic search(input bit sel, input int stall_var, input int stall_n,
                          input bit poke_busy, input bit poke_done);
        int left, pv, pp;
        bit stalled;
        got_v.delete(); got_p.delete();
        done_cyc = -1;
        left = stall_n;
        stalled = 1'b0;
        pv = 0; pp = 0;
        @(negedge clk);
        set_ready(1'b1);
        set_start(sel, 1'b1);
        @(posedge clk);
        #1 set_start(sel, 1'b0);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            grab(sel);
            if (stalled) begin
                check("stall_valid", s_valid, 1);
                check("stall_var", s_var, 32'(pv));
                check("stall_pol", s_pol, 32'(pp));
            end
            stalled = 1'b0;
            set_start(sel, poke_busy && k == 3);
            if (s_done === 1'b1) begin
                done_cyc = k;
                got_found = s_found;
                got_cnt = s_cnt;
                check("done_busy", s_busy, 0);
                check("done_valid", s_valid, 0);
                break;
            end
            if (s_valid === 1'b1 && int'(s_var) == stall_var && left > 0) begin
                set_ready(1'b0);
                left--;
                stalled = 1'b1;
                pv = int'(s_var);
                pp = int'(s_pol);
            end else begin
                set_ready(1'b1);
                if (s_valid === 1'b1) begin
                    got_v.push_back(int'(s_var));
                    got_p.push_back(int'(s_pol));
                end
            end
        end
        set_ready(1'b1);
        if (poke_done && done_cyc > 0) begin
            set_start(sel, 1'b1);
            @(negedge clk);
            grab(sel);
            check("start_in_done", s_busy, 0);
        end
        set_start(sel, 1'b0);
    endtask

    task automatic compare(input string tag);
        int n;
        check({tag, "_nlits"}, got_v.size(), exp_v.size());
        n = (got_v.size() < exp_v.size()) ? got_v.size() : exp_v.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_var%0d", tag, i), got_v[i], exp_v[i]);
            check($sformatf("%s_pol%0d", tag, i), got_p[i], exp_p[i]);
        end
        check({tag, "_done_cycle"}, done_cyc, exp_done);
        check({tag, "_found"}, got_found, (exp_v.size() > 0) ? 1 : 0);
        check({tag, "_pure_count"}, got_cnt, exp_v.size());
    endtask

    initial begin
        int pref[NV+1];
        int stall_var, stall_n;
        bit sel;

        rst_n = 1'b0;
        bus_a.start = 1'b0; bus_b.start = 1'b0;
        set_ready(1'b0);
        bus_a.clause_lits = '0; bus_b.clause_lits = '0;
        bus_a.clause_len = '0;  bus_b.clause_len = '0;
        bus_a.clause_act = '0;  bus_b.clause_act = '0;
        bus_a.num_clauses = '0; bus_b.num_clauses = '0;
        repeat (2) @(negedge clk);
        check_idle_zero("rst_a", 1'b0);
        check_idle_zero("rst_b", 1'b1);
        rst_n = 1'b1;

        // T1: full formula, single pure literal +4
        set_t1(); drive();
        model(1'b1, 0, 0);
        search(1'b0, 0, 0, 1'b1, 1'b1);
        compare("t1");
        check("t1_cycle18", done_cyc, 18);
        check("t1_lit", (got_v.size() > 0) ? got_v[0] : -1, 4);

        // T2: mask out clauses 1,2,8,9
        fact[1] = 0; fact[2] = 0; fact[8] = 0; fact[9] = 0; drive();
        model(1'b1, 0, 0);
        search(1'b0, 0, 0, 1'b0, 1'b0);
        compare("t2");
        check("t2_count5", got_cnt, 5);

        // T3: first-only variant
        model(1'b0, 0, 0);
        search(1'b1, 0, 0, 1'b0, 1'b0);
        compare("t3");
        check("t3_cycle12", done_cyc, 12);

        // T4: back-pressure on +3
        model(1'b1, 3, 3);
        search(1'b0, 3, 3, 1'b0, 1'b0);
        compare("t4");
        check("t4_cycle21", done_cyc, 21);

        // T5: empty formula, then clamped clause count
        fnc = 0; drive();
        model(1'b1, 0, 0);
        search(1'b0, 0, 0, 1'b0, 1'b0);
        compare("t5_empty");
        check("t5_cycle8", done_cyc, 8);
        set_t1(); fnc = 15; drive();
        model(1'b1, 0, 0);
        search(1'b0, 0, 0, 1'b0, 1'b0);
        compare("t5_clamp");
        check("t5_clamp_cycle18", done_cyc, 18);

        // T6: abort mid-scan, with a start pulse while busy
        set_t1(); drive();
        @(negedge clk); bus_a.start = 1'b1;
        @(posedge clk); #1 bus_a.start = 1'b0;
        @(negedge clk);
        @(negedge clk); bus_a.start = 1'b1;
        @(negedge clk);
        grab(1'b0);
        check("t6_busy", s_busy, 1);
        bus_a.start = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_idle_zero("t6_abort", 1'b0);
        repeat (3) begin
            @(negedge clk);
            grab(1'b0);
            check("t6_no_done", s_done, 0);
        end
        rst_n = 1'b1;
        model(1'b1, 0, 0);
        search(1'b0, 0, 0, 1'b0, 1'b0);
        compare("t6_rerun");

        // Randomized formulas; per-variable preferred sign keeps pure literals common.
        for (int it = 0; it < 24; it++) begin
            for (int v = 0; v <= NV; v++) pref[v] = $urandom_range(0, 1);
            fnc = $urandom_range(0, 15);
            for (int c = 0; c < MAX_CLAUSES; c++) begin
                flen[c] = $urandom_range(0, 7);
                fact[c] = ($urandom_range(0, 3) != 0) ? 1 : 0;
                for (int s = 0; s < MAX_LITS; s++) begin
                    fv[c][s] = $urandom_range(0, NV);
                    fp[c][s] = ($urandom_range(0, 5) == 0) ? 1 - pref[fv[c][s]] : pref[fv[c][s]];
                end
            end
            drive();
            sel = it[0];
            stall_var = $urandom_range(1, NV);
            stall_n = $urandom_range(0, 3);
            model(!sel, stall_var, stall_n);
            search(sel, stall_var, stall_n, 1'b0, 1'b0);
            compare($sformatf("rnd%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
